pkt_rx_frame_buf: RTL and testbench
===================================

PKT_RX_FRAME_BUF -- requirements
Module: pkt_rx_frame_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning bus width in bits (multiple of 8, 32..256).
REQ-002 SHALL have parameter DEPTH, default 512, meaning buffer words (power of 2, >=16).
REQ-003 SHALL have parameter FULL_THRESH, default 8, meaning free-word count at or below which pkt_rx_full asserts.
REQ-004 SHALL have derived localparam MOD_W = log2(DATA_W/8) and ADDR_W = log2(DEPTH).
REQ-005 SHALL have port clk_156m25  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset_156m25  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports pkt_in_val, pkt_in_sop, pkt_in_eop, pkt_in_err  input  1  write-side framing; err valid with eop.
REQ-008 SHALL have ports pkt_in_data  input  DATA_W  and  pkt_in_mod  input  MOD_W  write payload.
REQ-009 SHALL have port pkt_rx_full  output  1  almost-full backpressure to the source.
REQ-010 SHALL have port pkt_rx_ren  input  1  read request from consumer.
REQ-011 SHALL have port pkt_rx_avail  output  1  at least one complete committed packet stored.
REQ-012 SHALL have ports pkt_rx_val, pkt_rx_sop, pkt_rx_eop  output  1,  pkt_rx_data  output  DATA_W,  pkt_rx_mod  output  MOD_W  read payload.
REQ-013 SHALL have port drop_cnt  output  16  saturating count of dropped packets.

Function
REQ-014 SHALL store-and-forward: a packet becomes readable only after its eop word is written with pkt_in_err=0.
REQ-015 SHALL keep a committed write pointer and a speculative write pointer, both ADDR_W+1 bits, wrap-around by natural overflow.
REQ-016 SHALL run write FSM states IDLE, IN_PKT, DROP; IDLE->IN_PKT on val&sop, IN_PKT->IDLE on val&eop, ->DROP on overflow.
REQ-017 SHALL on drop rewind speculative pointer to committed pointer and increment drop_cnt, saturating at 16'hFFFF.
REQ-018 SHALL drop when: eop with err=1; write attempted with zero free words (overflow); sop received in IN_PKT (old packet dropped, new one starts same cycle).
REQ-019 SHALL in DROP discard words until val&eop, then return to IDLE; sop in DROP starts a new packet in IN_PKT.
REQ-020 SHALL ignore val words without sop while in IDLE (no drop count).
REQ-021 SHALL treat single-word packet (sop&eop same cycle) as complete; commit in that cycle.
REQ-022 SHALL compute free words from read pointer and speculative pointer; pkt_rx_full = free <= FULL_THRESH, registered.
REQ-023 SHALL store per word {sop, eop, mod, data}; mod=0 means all DATA_W/8 bytes valid, else mod bytes valid; mod ignored when eop=0.
REQ-024 SHALL maintain a committed-packet counter (ADDR_W+1 bits), +1 on commit, -1 when eop word read, both in same cycle -> unchanged.
REQ-025 SHALL assert pkt_rx_avail when committed-packet counter is nonzero.
REQ-026 SHALL on pkt_rx_ren with readable committed data present read one word; pkt_rx_val and payload appear exactly 1 cycle later.
REQ-027 SHALL ignore pkt_rx_ren when no committed word remains (pkt_rx_val stays 0, no pointer move).
REQ-028 SHALL allow simultaneous read and write in one cycle, including at full and at wrap.

Reset
REQ-029 SHALL on reset_156m25 clear all pointers and counters, FSM to IDLE, drop_cnt=0, pkt_rx_full=0, pkt_rx_avail=0, pkt_rx_val/sop/eop=0, pkt_rx_data=0, pkt_rx_mod=0.
REQ-030 SHALL discard any partial or stored packet when reset asserts mid-operation; RAM contents need not be cleared.

Structure
REQ-031 SHALL place write-FSM state enum and parameter defaults in shared package pkt_rx_pkg.
REQ-032 SHALL instantiate one sub-module pkt_rx_buf_ram: simple dual-port RAM, width DATA_W+MOD_W+2, registered read.

Verification
REQ-033 SHALL cover: 3-word packet (mod=5 on eop), ren held -> avail 1 after eop, 3 words out starting 1 cycle after first ren, eop mod=5.
REQ-034 SHALL cover: 4-word packet with err=1 on eop -> avail stays 0, drop_cnt=1, free words restored to DEPTH.
REQ-035 SHALL cover: DEPTH=16, 20-word packet, no reads -> overflow at word 17, drop_cnt=1, next 2-word packet accepted and read intact.
REQ-036 SHALL cover: sop mid-packet at word 3 -> first packet dropped, second packet delivered complete, drop_cnt=1.
REQ-037 SHALL cover: FULL_THRESH=8, DEPTH=16, 8 words written -> pkt_rx_full 1; one word read -> pkt_rx_full 0; pointers wrap across 5 back-to-back 7-word packets with concurrent reads, data intact.
REQ-038 SHALL cover: reset asserted mid-packet with one committed packet stored -> avail 0, val 0, drop_cnt 0, next packet delivered correctly.

Source files
------------

// File: rtl/pkt_rx_pkg.sv
// Shared types and parameter defaults for the rx frame buffer.
// No ports: write-FSM state enum plus default sizing constants.
package pkt_rx_pkg;

  localparam int DATA_W_DEF      = 64;
  localparam int DEPTH_DEF       = 512;
  localparam int FULL_THRESH_DEF = 8;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_IN_PKT,
    WR_DROP
  } wr_state_e;

endpackage

// File: rtl/pkt_rx_buf_ram.sv
// Simple dual-port RAM with registered read for the frame buffer.
// Ports: clk_i, write (we_i/waddr_i/wdata_i), read (re_i/raddr_i/rdata_o).
module pkt_rx_buf_ram #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/pkt_rx_frame_buf.sv
// Store-and-forward packet rx buffer: packets readable only once committed.
// Ports: write framing pkt_in_*, pkt_rx_full, read side pkt_rx_*, drop_cnt.
module pkt_rx_frame_buf
  import pkt_rx_pkg::*;
#(
  parameter  int DATA_W      = DATA_W_DEF,
  parameter  int DEPTH       = DEPTH_DEF,
  parameter  int FULL_THRESH = FULL_THRESH_DEF,
  localparam int MOD_W       = $clog2(DATA_W / 8),
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25,
  input  logic              pkt_in_val,
  input  logic              pkt_in_sop,
  input  logic              pkt_in_eop,
  input  logic              pkt_in_err,
  input  logic [DATA_W-1:0] pkt_in_data,
  input  logic [MOD_W-1:0]  pkt_in_mod,
  output logic              pkt_rx_full,
  input  logic              pkt_rx_ren,
  output logic              pkt_rx_avail,
  output logic              pkt_rx_val,
  output logic              pkt_rx_sop,
  output logic              pkt_rx_eop,
  output logic [DATA_W-1:0] pkt_rx_data,
  output logic [MOD_W-1:0]  pkt_rx_mod,
  output logic [15:0]       drop_cnt
);

  localparam int PW = ADDR_W + 1;
  localparam int RW = DATA_W + MOD_W + 2;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t THR_P   = ptr_t'(FULL_THRESH);

  wr_state_e   st_q, st_d;
  ptr_t        com_q, com_d;
  ptr_t        spec_q, spec_d;
  ptr_t        rd_q, rd_d;
  ptr_t        pcnt_q, pcnt_d;
  logic [15:0] drop_q, drop_d;
  logic        full_q, rval_q;

  ptr_t        wptr, wfree, free_d;
  logic        start, cont, wr_en, commit;
  logic [1:0]  drops;
  logic [16:0] dsum;
  logic        rd_en, rd_eop;
  logic [RW-1:0] wword, rword;

  // A restart (sop inside a packet) drops the old packet and writes
  // the new sop at the committed pointer in the same cycle.
  always_comb begin
    st_d   = st_q;
    spec_d = spec_q;
    com_d  = com_q;
    drops  = 2'd0;
    commit = 1'b0;
    wr_en  = 1'b0;
    start  = 1'b0;
    cont   = 1'b0;
    wptr   = spec_q;
    if (pkt_in_val) begin
      unique case (st_q)
        WR_IDLE: start = pkt_in_sop;
        WR_IN_PKT: begin
          if (pkt_in_sop) begin
            drops  = 2'd1;
            start  = 1'b1;
            wptr   = com_q;
            spec_d = com_q;
          end else begin
            cont = 1'b1;
          end
        end
        WR_DROP: begin
          start = pkt_in_sop;
          if (!pkt_in_sop && pkt_in_eop) st_d = WR_IDLE;
        end
        default: st_d = WR_IDLE;
      endcase
    end
    wfree = DEPTH_P - (wptr - rd_q);
    if (start || cont) begin
      if (wfree == '0) begin
        drops  = drops + 2'd1;
        spec_d = com_q;
        st_d   = pkt_in_eop ? WR_IDLE : WR_DROP;
      end else begin
        wr_en  = 1'b1;
        spec_d = wptr + ptr_t'(1);
        st_d   = WR_IN_PKT;
        if (pkt_in_eop) begin
          st_d = WR_IDLE;
          if (pkt_in_err) begin
            drops  = drops + 2'd1;
            spec_d = com_q;
          end else begin
            commit = 1'b1;
            com_d  = wptr + ptr_t'(1);
          end
        end
      end
    end
  end

  assign rd_en  = pkt_rx_ren && (com_q != rd_q);
  assign rd_d   = rd_q + ptr_t'(rd_en);
  assign rd_eop = rval_q & rword[RW-2];
  assign pcnt_d = pcnt_q + ptr_t'(commit) - ptr_t'(rd_eop);
  assign free_d = DEPTH_P - (spec_d - rd_d);

  assign dsum   = {1'b0, drop_q} + 17'(drops);
  assign drop_d = dsum[16] ? 16'hFFFF : dsum[15:0];

  assign wword = {pkt_in_sop, pkt_in_eop,
                  pkt_in_eop ? pkt_in_mod : {MOD_W{1'b0}},
                  pkt_in_data};

  pkt_rx_buf_ram #(
    .W  (RW),
    .AW (ADDR_W)
  ) u_ram (
    .clk_i   (clk_156m25),
    .we_i    (wr_en),
    .waddr_i (wptr[ADDR_W-1:0]),
    .wdata_i (wword),
    .re_i    (rd_en),
    .raddr_i (rd_q[ADDR_W-1:0]),
    .rdata_o (rword)
  );

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      st_q   <= WR_IDLE;
      com_q  <= '0;
      spec_q <= '0;
      rd_q   <= '0;
      pcnt_q <= '0;
      drop_q <= '0;
      full_q <= 1'b0;
      rval_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      com_q  <= com_d;
      spec_q <= spec_d;
      rd_q   <= rd_d;
      pcnt_q <= pcnt_d;
      drop_q <= drop_d;
      full_q <= (free_d <= THR_P);
      rval_q <= rd_en;
    end
  end

  // RAM read register has no reset; gate payload with the valid flag.
  assign pkt_rx_full  = full_q;
  assign pkt_rx_avail = (pcnt_q != '0);
  assign pkt_rx_val   = rval_q;
  assign pkt_rx_sop   = rval_q & rword[RW-1];
  assign pkt_rx_eop   = rd_eop;
  assign pkt_rx_mod   = rval_q ? rword[RW-3 -: MOD_W] : '0;
  assign pkt_rx_data  = rval_q ? rword[DATA_W-1:0] : '0;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_pkt_rx_frame_buf.sv
// Directed self-checking bench for pkt_rx_frame_buf (DEPTH=16, DATA_W=64).
// Scenarios: reset, basic, error drop, overflow, sop restart, full/wrap, reset mid-packet.
module tb_pkt_rx_frame_buf;

  localparam int DW = 64;
  localparam int DP = 16;
  localparam int FT = 8;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_val = 0, in_sop = 0, in_eop = 0, in_err = 0;
  logic [DW-1:0] in_data = '0;
  logic [MW-1:0] in_mod = '0;
  logic          rx_full, rx_ren = 0, rx_avail;
  logic          rx_val, rx_sop, rx_eop;
  logic [DW-1:0] rx_data;
  logic [MW-1:0] rx_mod;
  logic [15:0]   drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pkt_rx_frame_buf #(
    .DATA_W      (DW),
    .DEPTH       (DP),
    .FULL_THRESH (FT)
  ) dut (
    .clk_156m25   (clk),
    .reset_156m25 (rst),
    .pkt_in_val   (in_val),
    .pkt_in_sop   (in_sop),
    .pkt_in_eop   (in_eop),
    .pkt_in_err   (in_err),
    .pkt_in_data  (in_data),
    .pkt_in_mod   (in_mod),
    .pkt_rx_full  (rx_full),
    .pkt_rx_ren   (rx_ren),
    .pkt_rx_avail (rx_avail),
    .pkt_rx_val   (rx_val),
    .pkt_rx_sop   (rx_sop),
    .pkt_rx_eop   (rx_eop),
    .pkt_rx_data  (rx_data),
    .pkt_rx_mod   (rx_mod),
    .drop_cnt     (drop_cnt)
  );

  function automatic logic [63:0] mkd(input logic [7:0] tag, input int w);
    return {tag, 16'hC0DE, 32'h0, 8'(w)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic s, input logic e, input logic er,
                    input logic [63:0] d, input logic [2:0] m);
    in_val = 1; in_sop = s; in_eop = e; in_err = er;
    in_data = d; in_mod = m;
    tick();
    in_val = 0; in_sop = 0; in_eop = 0; in_err = 0;
  endtask

  task automatic send_pkt(input logic [7:0] tag, input int n,
                          input logic [2:0] m, input logic er);
    for (int w = 0; w < n; w++)
      wr(w == 0, w == n - 1, er && (w == n - 1), mkd(tag, w), m);
  endtask

  task automatic test_reset;
    rst = 1;
    tick();
    tick();
    checks++;
    if ({rx_full, rx_avail, rx_val, rx_sop, rx_eop} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000",
               {rx_full, rx_avail, rx_val, rx_sop, rx_eop});
    end
    checks++;
    if (rx_data !== '0 || rx_mod !== '0) begin
      errors++;
      $display("FAIL reset_payload got=%h/%0d exp=0/0", rx_data, rx_mod);
    end
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop got=%0d exp=0", drop_cnt);
    end
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic test_basic;
    send_pkt(8'h11, 3, 3'd5, 1'b0);
    checks++;
    if (rx_avail !== 1'b1) begin
      errors++;
      $display("FAIL basic_avail got=%b exp=1", rx_avail);
    end
    rx_ren = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rx_val, rx_sop, rx_eop} !== {1'b1, i == 0, i == 2}) begin
        errors++;
        $display("FAIL basic_flags w%0d got=%b exp=%b", i,
                 {rx_val, rx_sop, rx_eop}, {1'b1, i == 0, i == 2});
      end
      checks++;
      if (rx_data !== mkd(8'h11, i)) begin
        errors++;
        $display("FAIL basic_data w%0d got=%h exp=%h", i, rx_data, mkd(8'h11, i));
      end
    end
    checks++;
    if (rx_mod !== 3'd5) begin
      errors++;
      $display("FAIL basic_mod got=%0d exp=5", rx_mod);
    end
    tick();
    checks++;
    if (rx_val !== 1'b0 || rx_avail !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty got val=%b avail=%b exp 0 0", rx_val, rx_avail);
    end
    rx_ren = 0;
  endtask

  task automatic test_err_drop;
    send_pkt(8'h22, 4, 3'd0, 1'b1);
    checks++;
    if (rx_avail !== 1'b0 || drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL err_drop got avail=%b drop=%0d exp 0 1", rx_avail, drop_cnt);
    end
    send_pkt(8'h33, 16, 3'd4, 1'b0);
    checks++;
    if (rx_avail !== 1'b1 || drop_cnt !== 16'd1 || rx_full !== 1'b1) begin
      errors++;
      $display("FAIL err_refill got avail=%b drop=%0d full=%b exp 1 1 1",
               rx_avail, drop_cnt, rx_full);
    end
    rx_ren = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (rx_val !== 1'b1 || rx_data !== mkd(8'h33, i)) begin
        errors++;
        $display("FAIL err_drain w%0d got=%b/%h exp=1/%h", i, rx_val, rx_data,
                 mkd(8'h33, i));
      end
    end
    rx_ren = 0;
    tick();
    checks++;
    if (rx_full !== 1'b0 || rx_avail !== 1'b0) begin
      errors++;
      $display("FAIL err_after got full=%b avail=%b exp 0 0", rx_full, rx_avail);
    end
  endtask

  task automatic test_overflow;
    send_pkt(8'h44, 20, 3'd0, 1'b0);
    checks++;
    if (drop_cnt !== 16'd2 || rx_avail !== 1'b0 || rx_full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drop got drop=%0d avail=%b full=%b exp 2 0 0",
               drop_cnt, rx_avail, rx_full);
    end
    send_pkt(8'h55, 2, 3'd7, 1'b0);
    rx_ren = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({rx_val, rx_sop, rx_eop} !== {1'b1, i == 0, i == 1} ||
          rx_data !== mkd(8'h55, i)) begin
        errors++;
        $display("FAIL ovf_next w%0d got=%b/%h exp=%b/%h", i,
                 {rx_val, rx_sop, rx_eop}, rx_data, {1'b1, i == 0, i == 1},
                 mkd(8'h55, i));
      end
    end
    checks++;
    if (rx_mod !== 3'd7) begin
      errors++;
      $display("FAIL ovf_mod got=%0d exp=7", rx_mod);
    end
    rx_ren = 0;
    tick();
  endtask

  task automatic test_sop_mid;
    wr(1'b1, 1'b0, 1'b0, mkd(8'hA0, 0), 3'd0);
    wr(1'b0, 1'b0, 1'b0, mkd(8'hA0, 1), 3'd0);
    send_pkt(8'hA1, 3, 3'd6, 1'b0);
    checks++;
    if (drop_cnt !== 16'd3 || rx_avail !== 1'b1) begin
      errors++;
      $display("FAIL sop_mid got drop=%0d avail=%b exp 3 1", drop_cnt, rx_avail);
    end
    rx_ren = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rx_val, rx_sop, rx_eop} !== {1'b1, i == 0, i == 2} ||
          rx_data !== mkd(8'hA1, i)) begin
        errors++;
        $display("FAIL sop_mid_rd w%0d got=%b/%h exp=%b/%h", i,
                 {rx_val, rx_sop, rx_eop}, rx_data, {1'b1, i == 0, i == 2},
                 mkd(8'hA1, i));
      end
    end
    rx_ren = 0;
    tick();
    checks++;
    if (rx_avail !== 1'b0 || rx_val !== 1'b0) begin
      errors++;
      $display("FAIL sop_mid_end got avail=%b val=%b exp 0 0", rx_avail, rx_val);
    end
  endtask

  task automatic test_back_to_back;
    int got;
    send_pkt(8'h66, 8, 3'd1, 1'b0);
    checks++;
    if (rx_full !== 1'b1) begin
      errors++;
      $display("FAIL full_set got=%b exp=1", rx_full);
    end
    rx_ren = 1;
    tick();
    rx_ren = 0;
    checks++;
    if (rx_full !== 1'b0 || rx_val !== 1'b1 || rx_data !== mkd(8'h66, 0)) begin
      errors++;
      $display("FAIL full_clr got full=%b val=%b d=%h exp 0 1 %h",
               rx_full, rx_val, rx_data, mkd(8'h66, 0));
    end
    rx_ren = 1;
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (rx_val !== 1'b1 || rx_data !== mkd(8'h66, i)) begin
        errors++;
        $display("FAIL full_drain w%0d got=%b/%h exp=1/%h", i, rx_val, rx_data,
                 mkd(8'h66, i));
      end
    end
    rx_ren = 0;
    tick();
    got = 0;
    fork
      begin
        for (int p = 0; p < 5; p++)
          send_pkt(8'(8'hB0 + p), 7, 3'd3, 1'b0);
      end
      begin
        rx_ren = 1;
        for (int c = 0; c < 200 && got < 35; c++) begin
          tick();
          if (rx_val) begin
            checks++;
            if (rx_data !== mkd(8'(8'hB0 + got / 7), got % 7) ||
                rx_sop !== (got % 7 == 0) || rx_eop !== (got % 7 == 6) ||
                (rx_eop && rx_mod !== 3'd3)) begin
              errors++;
              $display("FAIL b2b w%0d got=%b%b/%0d/%h exp=%h", got, rx_sop,
                       rx_eop, rx_mod, rx_data,
                       mkd(8'(8'hB0 + got / 7), got % 7));
            end
            got++;
          end
        end
        rx_ren = 0;
      end
    join
    checks++;
    if (got != 35) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=35", got);
    end
    tick();
    checks++;
    if (rx_avail !== 1'b0 || drop_cnt !== 16'd3) begin
      errors++;
      $display("FAIL b2b_end got avail=%b drop=%0d exp 0 3", rx_avail, drop_cnt);
    end
  endtask

  task automatic test_reset_mid;
    send_pkt(8'h77, 2, 3'd1, 1'b0);
    wr(1'b1, 1'b0, 1'b0, mkd(8'h78, 0), 3'd0);
    wr(1'b0, 1'b0, 1'b0, mkd(8'h78, 1), 3'd0);
    checks++;
    if (rx_avail !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got avail=%b exp=1", rx_avail);
    end
    rst = 1;
    #2;
    checks++;
    if (rx_avail !== 1'b0 || rx_val !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rstmid got avail=%b val=%b drop=%0d exp 0 0 0",
               rx_avail, rx_val, drop_cnt);
    end
    @(negedge clk);
    rst = 0;
    tick();
    send_pkt(8'h88, 3, 3'd2, 1'b0);
    rx_ren = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rx_val, rx_sop, rx_eop} !== {1'b1, i == 0, i == 2} ||
          rx_data !== mkd(8'h88, i)) begin
        errors++;
        $display("FAIL rstmid_rd w%0d got=%b/%h exp=%b/%h", i,
                 {rx_val, rx_sop, rx_eop}, rx_data, {1'b1, i == 0, i == 2},
                 mkd(8'h88, i));
      end
    end
    checks++;
    if (rx_mod !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_mod got=%0d exp=2", rx_mod);
    end
    rx_ren = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err_drop();
    test_overflow();
    test_sop_mid();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
